// File: rtl/program_counter_writeback_unit.sv
// ============================================================================
// Module   : program_counter_writeback_unit
// Purpose  : 6502 PC register with load/increment and two-cycle relative branch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_counter_writeback_unit #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       inc,
  input  logic [7:0] adr_lo,
  input  logic [7:0] adr_hi,
  input  logic       branch_start,
  input  logic [7:0] offset,
  output logic [7:0] pcl_out,
  output logic [7:0] pch_out,
  output logic       busy,
  output logic       page_cross
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FIX  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  pcl, pch, pcl_next, pch_next;
  logic        fix_down, fix_down_next;
  logic        busy_next, page_cross_next;
  logic [8:0]  sum9;
  logic [15:0] src, src_inc;

  assign sum9    = {1'b0, pcl} + {1'b0, offset};
  assign src     = load ? {adr_hi, adr_lo} : {pch, pcl};
  assign src_inc = src + {15'd0, inc};

  always_comb begin
    state_next      = state;
    pcl_next        = pcl;
    pch_next        = pch;
    fix_down_next   = fix_down;
    busy_next       = 1'b0;
    page_cross_next = 1'b0;
    case (state)
      IDLE: begin
        if (branch_start) begin
          pcl_next = sum9[7:0];
          // Carry out with a positive offset, or no carry with a negative one,
          // means the target lies on an adjacent page.
          if (offset[7] ^ sum9[8]) begin
            state_next      = FIX;
            busy_next       = 1'b1;
            page_cross_next = 1'b1;
            fix_down_next   = offset[7];
          end
        end else begin
          {pch_next, pcl_next} = src_inc;
        end
      end
      FIX: begin
        pch_next   = fix_down ? (pch - 8'd1) : (pch + 8'd1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pcl        <= RESET_PC[7:0];
      pch        <= RESET_PC[15:8];
      fix_down   <= 1'b0;
      busy       <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      state      <= state_next;
      pcl        <= pcl_next;
      pch        <= pch_next;
      fix_down   <= fix_down_next;
      busy       <= busy_next;
      page_cross <= page_cross_next;
    end
  end

  assign pcl_out = pcl;
  assign pch_out = pch;

endmodule

`default_nettype wire
